// File: rtl/tans_pkg.sv
// Shared tANS tables (L=8, 3-symbol alphabet) and Huffman code definitions
// used by both the Huffman->tANS recoder and its inverse.
package tans_pkg;

  localparam int unsigned L       = 8;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned NB_W    = 2;
  localparam int unsigned CHUNK_W = 3;

  typedef enum logic [1:0] {SYM_A, SYM_B, SYM_C} sym_t;
  typedef logic [STATE_W-1:0] state_t;

  typedef struct packed {
    sym_t              sym;
    state_t            y;
    logic [NB_W-1:0]   nb;
  } dec_entry_t;

  // Decode table indexed by X-L
  localparam sym_t DEC_SYM [L] = '{SYM_A, SYM_A, SYM_B, SYM_A, SYM_C, SYM_A, SYM_B, SYM_A};
  localparam state_t DEC_Y [L] = '{4'd5, 4'd6, 4'd2, 4'd7, 4'd1, 4'd8, 4'd3, 4'd9};
  localparam logic [NB_W-1:0] DEC_NB [L] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0};

  // Huffman codes, first-emitted bit in [1]: A=0, B=10, C=11
  localparam logic [1:0] HUF_LEN  [3] = '{2'd1, 2'd2, 2'd2};
  localparam logic [1:0] HUF_BITS [3] = '{2'b00, 2'b10, 2'b11};

  function automatic dec_entry_t dec_lookup(input state_t x);
    logic [2:0] idx;
    dec_entry_t e;
    idx   = 3'(x - 4'(L));
    e.sym = DEC_SYM[idx];
    e.y   = DEC_Y[idx];
    e.nb  = DEC_NB[idx];
    return e;
  endfunction

endpackage

// File: rtl/tans_dec_table.sv
// Combinational tANS decode lookup: state X -> {symbol, base y, bit count nb}.
module tans_dec_table
  import tans_pkg::*;
(
  input  state_t     x,
  output dec_entry_t entry_c
);

  assign entry_c = dec_lookup(x);

endmodule

// File: rtl/tans_hf_recoder.sv
// Decodes a LIFO tANS chunk stream and re-emits each symbol as serial Huffman bits.
module tans_hf_recoder
  import tans_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter state_t      INIT_STATE = 4'd8
) (
  input  logic               PHI,
  input  logic               RST,
  input  logic               start,
  input  state_t             init_state,
  input  logic [CNT_W-1:0]   sym_count,
  output logic               busy,
  output logic [NB_W-1:0]    req_bits,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               done,
  output state_t             final_state,
  output logic               state_err
);

  typedef enum logic [2:0] {IDLE, EMIT1, EMIT2, FETCH, DONE} fsm_t;

  fsm_t             fsm_q, fsm_d;
  state_t           x_q, x_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dec_entry_t       cur_q, nxt_c;
  logic [CHUNK_W-1:0] chunk_mask;
  state_t           x_fetch;

  logic             busy_d, in_ready_d, out_bit_d, out_valid_d, done_d, state_err_d;
  logic [NB_W-1:0]  req_bits_d;
  state_t           final_state_d;

  // Lookup on the next X so outputs and the cached entry are registered together
  tans_dec_table u_dec (
    .x       (x_d),
    .entry_c (nxt_c)
  );

  always_comb begin
    fsm_d         = fsm_q;
    x_d           = x_q;
    cnt_d         = cnt_q;
    chunk_mask    = 3'((4'd1 << cur_q.nb) - 4'd1);
    x_fetch       = 4'((cur_q.y << cur_q.nb) | {1'b0, in_data & chunk_mask});
    final_state_d = final_state;
    state_err_d   = state_err;

    case (fsm_q)
      IDLE: begin
        if (start) begin
          x_d   = init_state;
          cnt_d = sym_count;
          fsm_d = (sym_count == '0) ? DONE : EMIT1;
        end
      end
      EMIT1: begin
        if (out_ready) fsm_d = (HUF_LEN[cur_q.sym] == 2'd2) ? EMIT2 : FETCH;
      end
      EMIT2: begin
        if (out_ready) fsm_d = FETCH;
      end
      FETCH: begin
        if (cur_q.nb == '0 || in_valid) begin
          x_d   = x_fetch;
          cnt_d = cnt_q - CNT_W'(1);
          fsm_d = (cnt_q == CNT_W'(1)) ? DONE : EMIT1;
        end
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase

    busy_d      = (fsm_d != IDLE);
    out_valid_d = (fsm_d == EMIT1) || (fsm_d == EMIT2);
    out_bit_d   = 1'b0;
    if (fsm_d == EMIT1) out_bit_d = HUF_BITS[nxt_c.sym][1];
    if (fsm_d == EMIT2) out_bit_d = HUF_BITS[nxt_c.sym][0];
    req_bits_d  = (fsm_d == FETCH) ? nxt_c.nb : '0;
    in_ready_d  = (fsm_d == FETCH) && (nxt_c.nb != '0);
    done_d      = (fsm_d == DONE);
    if (fsm_d == DONE) begin
      final_state_d = x_d;
      state_err_d   = (x_d != INIT_STATE);
    end
  end

  always_ff @(posedge PHI or negedge RST) begin
    if (!RST) begin
      fsm_q       <= IDLE;
      x_q         <= INIT_STATE;
      cnt_q       <= '0;
      cur_q       <= dec_lookup(INIT_STATE);
      busy        <= 1'b0;
      req_bits    <= '0;
      in_ready    <= 1'b0;
      out_bit     <= 1'b0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      final_state <= INIT_STATE;
      state_err   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      x_q         <= x_d;
      cnt_q       <= cnt_d;
      cur_q       <= nxt_c;
      busy        <= busy_d;
      req_bits    <= req_bits_d;
      in_ready    <= in_ready_d;
      out_bit     <= out_bit_d;
      out_valid   <= out_valid_d;
      done        <= done_d;
      final_state <= final_state_d;
      state_err   <= state_err_d;
    end
  end

endmodule

// File: tb/tb_tans_hf_recoder.sv
// Directed, table-driven bench for tans_hf_recoder with reset and backpressure sequences.
module tb_tans_hf_recoder;

  logic       PHI, RST, start;
  logic [3:0] init_state;
  logic [7:0] sym_count;
  logic       busy;
  logic [1:0] req_bits;
  logic [2:0] in_data;
  logic       in_valid, in_ready, out_bit, out_valid, out_ready, done;
  logic [3:0] final_state;
  logic       state_err;

  int checks = 0;
  int failures = 0;

  tans_hf_recoder #(.CNT_W(8), .INIT_STATE(4'd8)) dut (
    .PHI         (PHI),
    .RST         (RST),
    .start       (start),
    .init_state  (init_state),
    .sym_count   (sym_count),
    .busy        (busy),
    .req_bits    (req_bits),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_bit     (out_bit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .done        (done),
    .final_state (final_state),
    .state_err   (state_err)
  );

  initial PHI = 1'b0;
  always #5 PHI = ~PHI;

  typedef struct packed {
    logic [3:0]  init;
    logic [7:0]  cnt;
    logic [11:0] chunks;   // chunk k at [3k+:3], in delivery order
    logic [3:0]  nchunks;
    logic [7:0]  bits;     // Huffman bit k at [k]
    logic [3:0]  nbits;
    logic [1:0]  req0;     // req_bits in the first FETCH cycle
    logic [3:0]  fin;
    logic        err;
    logic [1:0]  stall;    // cycles of out_ready=0 on the first bit
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [7:0] got;
    logic [1:0] req0;
    int ng, nch, stall_left, cyc;
    bit seen_fetch, finished;
    got = '0; req0 = '0; ng = 0; nch = 0; stall_left = int'(v.stall);
    seen_fetch = 0; finished = 0;
    @(negedge PHI);
    start = 1'b1; init_state = v.init; sym_count = v.cnt;
    @(negedge PHI);
    start = 1'b0; out_ready = 1'b1;
    for (cyc = 0; cyc < 200 && !finished; cyc++) begin
      in_valid = 1'b0;
      if (done) begin
        finished = 1;
      end else begin
        if (out_valid) begin
          if (ng == 0 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
            chk($sformatf("v%0d_stall_hold", id), 32'(out_bit), 32'(v.bits[0]));
          end else begin
            out_ready = 1'b1;
            if (ng < 8) got[ng] = out_bit;
            ng++;
          end
        end
        if (busy && !out_valid && !seen_fetch) begin
          seen_fetch = 1;
          req0 = req_bits;
        end
        if (in_ready) begin
          in_valid = 1'b1;
          in_data  = (nch < 4) ? v.chunks[3*nch +: 3] : 3'b000;
          nch++;
        end
        @(negedge PHI);
      end
    end
    chk($sformatf("v%0d_done_seen", id), 32'(finished), 32'd1);
    chk($sformatf("v%0d_bit_count", id), 32'(ng), 32'(v.nbits));
    chk($sformatf("v%0d_bits", id), 32'(got), 32'(v.bits));
    chk($sformatf("v%0d_chunks_used", id), 32'(nch), 32'(v.nchunks));
    chk($sformatf("v%0d_first_req", id), 32'(req0), 32'(v.req0));
    chk($sformatf("v%0d_final_state", id), 32'(final_state), 32'(v.fin));
    chk($sformatf("v%0d_state_err", id), 32'(state_err), 32'(v.err));
    if (v.cnt == 8'd0) chk($sformatf("v%0d_zero_latency", id), 32'(cyc <= 2), 32'd1);
    @(negedge PHI);
    chk($sformatf("v%0d_done_one_cycle", id), 32'(done), 32'd0);
    chk($sformatf("v%0d_idle", id), 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    vecs[0] = '{init:4'd13, cnt:8'd1, chunks:12'h000, nchunks:4'd0, bits:8'b0000_0000, nbits:4'd1, req0:2'd0, fin:4'd8,  err:1'b0, stall:2'd0};
    vecs[1] = '{init:4'd10, cnt:8'd1, chunks:12'h000, nchunks:4'd1, bits:8'b0000_0001, nbits:4'd2, req0:2'd2, fin:4'd8,  err:1'b0, stall:2'd0};
    vecs[2] = '{init:4'd12, cnt:8'd1, chunks:12'h000, nchunks:4'd1, bits:8'b0000_0011, nbits:4'd2, req0:2'd3, fin:4'd8,  err:1'b0, stall:2'd0};
    vecs[3] = '{init:4'd10, cnt:8'd1, chunks:12'h001, nchunks:4'd1, bits:8'b0000_0001, nbits:4'd2, req0:2'd2, fin:4'd9,  err:1'b1, stall:2'd0};
    vecs[4] = '{init:4'd14, cnt:8'd2, chunks:12'h001, nchunks:4'd1, bits:8'b0000_0001, nbits:4'd3, req0:2'd2, fin:4'd8,  err:1'b0, stall:2'd3};
    vecs[5] = '{init:4'd11, cnt:8'd0, chunks:12'h000, nchunks:4'd0, bits:8'b0000_0000, nbits:4'd0, req0:2'd0, fin:4'd11, err:1'b1, stall:2'd0};
    vecs[6] = '{init:4'd8,  cnt:8'd3, chunks:12'h081, nchunks:4'd3, bits:8'b0000_0100, nbits:4'd4, req0:2'd1, fin:4'd14, err:1'b1, stall:2'd0};
    vecs[7] = '{init:4'd15, cnt:8'd2, chunks:12'h000, nchunks:4'd1, bits:8'b0000_0000, nbits:4'd2, req0:2'd0, fin:4'd12, err:1'b1, stall:2'd0};
    vecs[8] = '{init:4'd9,  cnt:8'd2, chunks:12'h001, nchunks:4'd1, bits:8'b0000_0000, nbits:4'd2, req0:2'd1, fin:4'd8,  err:1'b0, stall:2'd0};

    RST = 1'b0; start = 1'b0; init_state = '0; sym_count = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge PHI);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_req_bits", 32'(req_bits), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_final_state", 32'(final_state), 32'd8);
    chk("rst_state_err", 32'(state_err), 32'd0);
    RST = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Leave final_state=9/state_err=1 so the reset below has something to clear
    run_vec(9, vecs[3]);
    @(negedge PHI);
    start = 1'b1; init_state = 4'd10; sym_count = 8'd1;
    @(negedge PHI);
    start = 1'b0; out_ready = 1'b1;
    chk("mid_emit1_bit", 32'(out_bit), 32'd1);
    @(negedge PHI);
    chk("mid_emit2_valid", 32'(out_valid), 32'd1);
    chk("mid_emit2_bit", 32'(out_bit), 32'd0);
    RST = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_bit", 32'(out_bit), 32'd0);
    chk("mid_rst_final_state", 32'(final_state), 32'd8);
    chk("mid_rst_state_err", 32'(state_err), 32'd0);
    @(negedge PHI);
    RST = 1'b1;
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge PHI);
      in_valid = 1'b1; in_data = 3'b000;
      if (done || busy) ndone++;
    end
    in_valid = 1'b0;
    chk("mid_rst_no_done", 32'(ndone), 32'd0);
    run_vec(10, vecs[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tans_hf_recoder.md
Name: tANS_HF_recoder

Overview:
- Inverse of the Huffman-to-tANS recoder: decodes a tANS bit-chunk stream (3-symbol alphabet A/B/C, L=8, 4-bit state 8..15) and re-emits the symbols as a serial Huffman bitstream (A=0, B=1 then 0, C=1 then 1).
- Sits downstream of the chunk buffer, which supplies chunks in reverse emission order (LIFO), so decoded symbols come out in original order.
- Feeds the serial Huffman consumer.

Parameters:
- CNT_W, 8, width of the symbol-count input and internal counter.
- INIT_STATE, 8, encoder start state; the decoder's final state is checked against it.

Ports:
- PHI  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; sampled only in IDLE.
- init_state  in  4  final tANS state from the encoder; captured on start.
- sym_count  in  CNT_W  number of symbols to decode; captured on start.
- busy  out  1  high in every state except IDLE.
- req_bits  out  2  bit count needed for the current state (0..3); valid in FETCH, 0 otherwise.
- in_data  in  3  chunk, right-aligned; only in_data[req_bits-1:0] is used.
- in_valid  in  1  chunk valid.
- in_ready  out  1  high in FETCH when req_bits!=0.
- out_bit  out  1  Huffman bit.
- out_valid  out  1  out_bit valid.
- out_ready  in  1  consumer accepts out_bit.
- done  out  1  one-cycle pulse at the end of a block.
- final_state  out  4  state after the last decode step; held until the next start.
- state_err  out  1  final_state!=INIT_STATE; updated with done, held until the next start.

Behaviour:
- Decode table (package constant, index i=X-8, entries sym/y/nb):
  - 0: A/5/1
  - 1: A/6/1
  - 2: B/2/2
  - 3: A/7/1
  - 4: C/1/3
  - 5: A/8/0
  - 6: B/3/2
  - 7: A/9/0
- Next state: X' = (y<<nb) | in_data[nb-1:0]; when nb=0, X' = y. X' is always in 8..15.
- Reset (async, RST=0) forces:
  - state=IDLE, X=INIT_STATE, cnt=0;
  - all outputs 0 (final_state=INIT_STATE, state_err=0).
  - Reset mid-block abandons the block; no done pulse.
- IDLE:
  - On start: X<=init_state, cnt<=sym_count, final_state/state_err keep their old values.
  - Next state is EMIT1, or DONE if sym_count=0.
  - Any init_state<8 is a caller error; behaviour undefined.
- EMIT1:
  - out_valid=1; out_bit = 0 for A, 1 for B/C.
  - On out_ready: B/C go to EMIT2, A goes to FETCH.
  - out_bit stays stable while out_ready=0.
- EMIT2:
  - out_valid=1; out_bit = 0 for B, 1 for C.
  - On out_ready, go to FETCH.
- FETCH:
  - req_bits=nb[X].
  - If nb=0: update X, decrement cnt in the same cycle, no input handshake.
  - Else: in_ready=1; on in_valid, update X and decrement cnt.
  - Then go to DONE if cnt was 1, else EMIT1.
- DONE:
  - done=1 for one cycle; final_state<=X, state_err<=(X!=INIT_STATE), both registered so they are visible with done.
  - Next state IDLE.
- start outside IDLE is ignored.
- in_valid outside FETCH is ignored.
- Latency: minimum 2 cycles per A (EMIT1, FETCH) and 3 per B/C, plus 1 for DONE.

Decomposition:
- Package tans_pkg holds:
  - typedef sym_t {SYM_A, SYM_B, SYM_C};
  - typedef state_t logic[3:0];
  - constant arrays DEC_SYM[8], DEC_Y[8], DEC_NB[8];
  - the Huffman code length/bits per symbol;
  - L=8.
  - The existing recoder imports the same package so both directions share one table.
- One natural sub-module: tans_dec_table, a combinational lookup from X to {sym, y, nb}.

Test Plan:
- Single A: start, init_state=13, sym_count=1, out_ready=1 -> out_bit 0; req_bits 0; no in_ready; done with final_state=8, state_err=0.
- Single B: init_state=10, count=1, in_data=3'b000 -> out_bits 1,0; req_bits=2; final_state=8, state_err=0.
- Single C: init_state=12, count=1, in_data=3'b000 -> out_bits 1,1; req_bits=3; final_state=8.
- Two symbols with backpressure: init_state=14, count=2, chunk 2'b01, out_ready low 3 cycles during the first bit -> out_bit held at 1 while stalled; out bits 1,0,0; X goes 14->13->8; done pulses once, state_err=0.
- Error and corner cases:
  - init_state=10, count=1, in_data=01 -> final_state=9, state_err=1.
  - sym_count=0 -> done within 2 cycles, final_state=init_state.
- Async reset mid-block: RST low during EMIT2 -> outputs 0 immediately, no done; a new start then decodes normally.
